// File: rtl/fx_param_sched.sv
// rtl/fx_param_sched.sv - click-free effect parameter scheduler and output gain stage
// Build option: define FX_SCHED_FADE_EN for the fade-out / commit / hold / fade-in sequence;
// when undefined, pending frames commit on the next sample strobe at constant unity gain.
module fx_param_sched #(
  parameter int FRAME_W      = 240,
  parameter int RAMP_LOG2    = 5,
  parameter int HOLD_SAMPLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [FRAME_W-1:0]  cmd_data,
  input  logic                cmd_valid,
  input  logic                sample_stb,
  input  logic signed [15:0]  audio_in_0,
  input  logic signed [15:0]  audio_in_1,
  output logic signed [15:0]  audio_out_0,
  output logic signed [15:0]  audio_out_1,
  output logic [FRAME_W-1:0]  param_out,
  output logic                param_commit,
  output logic                busy,
  output logic                pending,
  output logic [7:0]          drop_cnt
);

  localparam logic [8:0] GAIN_FULL = 9'd256;

  // Reject configurations the ramp and hold counter cannot represent
  if (RAMP_LOG2 < 0 || RAMP_LOG2 > 8 || HOLD_SAMPLES < 0 || HOLD_SAMPLES > 255 || FRAME_W < 1)
  begin : g_cfg_check
    $error("fx_param_sched: parameter out of range");
  end

  logic [FRAME_W-1:0] pend_reg;
  logic [8:0]         gain;
  logic               commit_now;

`ifdef FX_SCHED_FADE_EN
  localparam logic [8:0] STEP      = 9'(256 >> RAMP_LOG2);
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_SAMPLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FADE_OUT,
    ST_COMMIT,
    ST_HOLD,
    ST_FADE_IN
  } state_t;

  state_t     state;
  logic [7:0] hold_cnt;

  assign commit_now = (state == ST_COMMIT);
  assign busy       = (state != ST_IDLE);

  // Fade sequencer: ramps gain on sample strobes and commits only while fully muted
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gain     <= GAIN_FULL;
      hold_cnt <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending) state <= ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          // A reversal that already reached silence commits without waiting for a strobe
          if (gain == 9'd0) begin
            state <= ST_COMMIT;
          end else if (sample_stb) begin
            if (gain <= STEP) begin
              gain  <= 9'd0;
              state <= ST_COMMIT;
            end else begin
              gain <= gain - STEP;
            end
          end
        end
        ST_COMMIT: begin
          hold_cnt <= HOLD_INIT;
          state    <= (HOLD_INIT == 8'd0) ? ST_FADE_IN : ST_HOLD;
        end
        ST_HOLD: begin
          if (sample_stb) begin
            if (hold_cnt <= 8'd1) begin
              hold_cnt <= 8'd0;
              state    <= ST_FADE_IN;
            end else begin
              hold_cnt <= hold_cnt - 8'd1;
            end
          end
        end
        ST_FADE_IN: begin
          if (pending) begin
            // Reverse from the current gain so the ramp stays continuous
            state <= ST_FADE_OUT;
            if (sample_stb && gain >= STEP) gain <= gain - STEP;
          end else if (sample_stb) begin
            if (gain >= GAIN_FULL - STEP) begin
              gain  <= GAIN_FULL;
              state <= ST_IDLE;
            end else begin
              gain <= gain + STEP;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
`else
  // Without fading the chain always runs at unity gain; commits ride on the sample strobe
  assign gain       = GAIN_FULL;
  assign commit_now = sample_stb & pending;
  assign busy       = pending;
`endif

  // Command capture: latest frame wins, overwrites are counted, no-op frames are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg     <= '0;
      pending      <= 1'b0;
      drop_cnt     <= 8'd0;
      param_out    <= '0;
      param_commit <= 1'b0;
    end else begin
      param_commit <= commit_now;
      if (commit_now) param_out <= pend_reg;
      if (cmd_valid) begin
        if (commit_now) begin
          // The old frame leaves this cycle, so the new one is a fresh capture, not a drop
          pend_reg <= cmd_data;
          pending  <= 1'b1;
        end else if (pending) begin
          pend_reg <= cmd_data;
          if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end else if (cmd_data != param_out) begin
          pend_reg <= cmd_data;
          pending  <= 1'b1;
        end
      end else if (commit_now) begin
        pending <= 1'b0;
      end
    end
  end

  // Signed sample times unsigned 9-bit gain, scaled back by 256 (gain 256 is exact)
  function automatic logic signed [15:0] apply_gain(input logic signed [15:0] s,
                                                    input logic [8:0] g);
    logic signed [25:0] p;
    p = 26'(s) * $signed({17'd0, g});
    return 16'(p >>> 8);
  endfunction

  // Output gain stage: each strobe scales the stereo pair by the gain before its ramp step
  always_ff @(posedge clk) begin
    if (reset) begin
      audio_out_0 <= '0;
      audio_out_1 <= '0;
    end else if (sample_stb) begin
      audio_out_0 <= apply_gain(audio_in_0, gain);
      audio_out_1 <= apply_gain(audio_in_1, gain);
    end
  end

endmodule

// File: tb/tb_fx_param_sched.sv
// tb/tb_fx_param_sched.sv - directed vector bench for fx_param_sched
module tb_fx_param_sched;

  localparam int FRAME_W = 240;

  logic                clk = 1'b0;
  logic                reset;
  logic [FRAME_W-1:0]  cmd_data;
  logic                cmd_valid;
  logic                sample_stb;
  logic signed [15:0]  audio_in_0, audio_in_1;
  logic signed [15:0]  audio_out_0, audio_out_1;
  logic [FRAME_W-1:0]  param_out;
  logic                param_commit, busy, pending;
  logic [7:0]          drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int commit_cnt = 0;

  always #5 clk = ~clk;

  fx_param_sched #(.FRAME_W(FRAME_W), .RAMP_LOG2(5), .HOLD_SAMPLES(4)) dut (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .sample_stb(sample_stb), .audio_in_0(audio_in_0), .audio_in_1(audio_in_1),
    .audio_out_0(audio_out_0), .audio_out_1(audio_out_1), .param_out(param_out),
    .param_commit(param_commit), .busy(busy), .pending(pending), .drop_cnt(drop_cnt)
  );

  always @(negedge clk) if (param_commit) commit_cnt++;

  typedef struct {
    logic [15:0] in0;
    logic [15:0] in1;
    logic [15:0] exp0;
    logic [15:0] exp1;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] ramp0[1:69];
  logic [15:0] ramp1[1:69];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic stb(input logic [15:0] a0, input logic [15:0] a1);
    @(negedge clk);
    audio_in_0 = a0;
    audio_in_1 = a1;
    sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    tick(3);
  endtask

  task automatic send(input logic [FRAME_W-1:0] f);
    @(negedge clk);
    cmd_data  = f;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_idle();
    for (int i = 0; i < 120 && (busy || pending); i++) stb(16'h4000, 16'hC000);
    chk("settle_busy", busy, 0);
  endtask

  initial begin
    logic [FRAME_W-1:0] f0, f1, f2, f3, f4, last_ow;
    int c0, g;
    f0 = {8{30'h2345678}};
    f1 = {8{30'h1111111}};
    f2 = {8{30'h2222222}};
    f3 = {8{30'h3333333}};
    f4 = {8{30'h0ABCDEF}};

    vecs[0] = '{16'h1234, 16'hEDCC, 16'h1234, 16'hEDCC};
    vecs[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
    vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[3] = '{16'h0001, 16'h4000, 16'h0001, 16'h4000};
    vecs[4] = '{16'hC000, 16'h0100, 16'hC000, 16'h0100};
    vecs[5] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234};

    // Fade profile for in0 = 0x4000, in1 = -0x4000: 32 down, 4 held, 32 up, then unity
    for (int k = 1; k <= 69; k++) begin
      if (k <= 32)      g = 256 - 8 * (k - 1);
      else if (k <= 37) g = 0;
      else if (k <= 68) g = 8 * (k - 37);
      else              g = 256;
      ramp0[k] = 16'(64 * g);
      ramp1[k] = 16'(-64 * g);
    end

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = '0; sample_stb = 1'b0;
    audio_in_0 = '0; audio_in_1 = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("rst_param_out", param_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_audio_out_0", {audio_out_0}, 0);
    chk("rst_commit", commit_cnt, 0);

    for (int i = 0; i < 6; i++) begin
      stb(vecs[i].in0, vecs[i].in1);
      chk($sformatf("pass_out0[%0d]", i), {audio_out_0}, vecs[i].exp0);
      chk($sformatf("pass_out1[%0d]", i), {audio_out_1}, vecs[i].exp1);
      chk($sformatf("pass_busy[%0d]", i), busy, 0);
    end

`ifdef FX_SCHED_FADE_EN
    // Single frame: full fade-out, commit, hold, fade-in
    c0 = commit_cnt;
    send(f0);
    tick(2);
    chk("f0_pending", pending, 1);
    for (int k = 1; k <= 69; k++) begin
      stb(16'h4000, 16'hC000);
      chk($sformatf("ramp_out0[%0d]", k), {audio_out_0}, ramp0[k]);
      chk($sformatf("ramp_out1[%0d]", k), {audio_out_1}, ramp1[k]);
      if (k == 31) chk("f0_no_commit_yet", commit_cnt, c0);
      if (k == 32) begin
        chk("f0_commit_once", commit_cnt, c0 + 1);
        chk("f0_param_out", param_out, f0);
        chk("f0_pending_clr", pending, 0);
      end
      if (k == 67) chk("f0_busy_67", busy, 1);
      if (k == 68) chk("f0_busy_68", busy, 0);
    end
    chk("f0_commit_total", commit_cnt, c0 + 1);

    // Second frame overwrites the first during fade-out
    c0 = commit_cnt;
    send(f1);
    tick(2);
    repeat (5) stb(16'h4000, 16'hC000);
    send(f2);
    run_to_idle();
    chk("ow_param_out", param_out, f2);
    chk("ow_drop_cnt", drop_cnt, 1);
    chk("ow_commit_once", commit_cnt, c0 + 1);

    // New frame halfway up the fade-in reverses the ramp from gain 128
    c0 = commit_cnt;
    send(f3);
    tick(2);
    repeat (52) stb(16'h4000, 16'hC000);
    chk("rev_f3_commit", commit_cnt, c0 + 1);
    chk("rev_f3_busy", busy, 1);
    send(f4);
    tick(2);
    c0 = commit_cnt;
    stb(16'h4000, 16'hC000);
    chk("rev_out_g128", {audio_out_0}, 16'h2000);
    stb(16'h4000, 16'hC000);
    chk("rev_out_g120", {audio_out_0}, 16'h1E00);
    repeat (13) stb(16'h4000, 16'hC000);
    chk("rev_no_commit_15", commit_cnt, c0);
    stb(16'h4000, 16'hC000);
    chk("rev_commit_16", commit_cnt, c0 + 1);
    chk("rev_param_out", param_out, f4);
    run_to_idle();
`else
    // Without fading: frame waits for the next strobe, audio passes untouched
    c0 = commit_cnt;
    send(f0);
    tick(2);
    chk("nf_pending", pending, 1);
    chk("nf_busy", busy, 1);
    chk("nf_param_hold", param_out, 0);
    @(negedge clk);
    audio_in_0 = 16'h1234; audio_in_1 = 16'hABCD; sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    chk("nf_commit_pulse", param_commit, 1);
    chk("nf_param_out", param_out, f0);
    tick(1);
    chk("nf_commit_pulse_end", param_commit, 0);
    chk("nf_out0", {audio_out_0}, 16'h1234);
    chk("nf_out1", {audio_out_1}, 16'hABCD);
    chk("nf_pending_clr", pending, 0);
    chk("nf_commit_once", commit_cnt, c0 + 1);

    c0 = commit_cnt;
    send(f1);
    send(f2);
    chk("nf_ow_drop", drop_cnt, 1);
    stb(16'h4000, 16'hC000);
    chk("nf_ow_param_out", param_out, f2);
    chk("nf_ow_commit_once", commit_cnt, c0 + 1);
    chk("nf_ow_out0", {audio_out_0}, 16'h4000);
    f4 = f2;
`endif

    // A frame equal to the active parameters is a no-op
    c0 = commit_cnt;
    g  = int'(drop_cnt);
    send(f4);
    tick(3);
    chk("eq_busy", busy, 0);
    chk("eq_pending", pending, 0);
    chk("eq_commit", commit_cnt, c0);
    chk("eq_drop", drop_cnt, g);

    // 301 frames without a strobe: one capture and 300 overwrites saturate the counter
    for (int i = 0; i <= 300; i++) send(FRAME_W'(i + 77));
    last_ow = FRAME_W'(377);
    chk("sat_drop_cnt", drop_cnt, 255);
    chk("sat_pending", pending, 1);

`ifdef FX_SCHED_FADE_EN
    repeat (34) stb(16'h4000, 16'hC000);
    chk("hold_param_out", param_out, last_ow);
    chk("hold_busy", busy, 1);
    chk("hold_out0", {audio_out_0}, 0);
`else
    chk("sat_param_hold", param_out, f4);
`endif

    // Reset mid-operation drops everything back to power-on values
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_param_out", param_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_drop_cnt", drop_cnt, 0);
    chk("mid_rst_audio_out_1", {audio_out_1}, 0);
    stb(16'h1234, 16'h8001);
    chk("mid_rst_unity_out0", {audio_out_0}, 16'h1234);
    chk("mid_rst_unity_out1", {audio_out_1}, 16'h8001);
    chk("mid_rst_stays_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
